// File: rtl/tdm_pkg.sv
// Shared definitions for the two-slot TDM receive path: state encoding and
// default widths used by tdm_demux and its counters.
package tdm_pkg;

  localparam int N_DEF     = 3;
  localparam int CNT_W_DEF = 8;

  localparam logic ST_HUNT  = 1'b0;
  localparam logic ST_GOT_A = 1'b1;

endpackage : tdm_pkg

// File: rtl/tdm_demux_sat_counter.sv
// Event counter with a selectable overflow policy: WRAP=1 rolls over to zero,
// WRAP=0 sticks at all-ones.
module sat_counter #(
  parameter int W    = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_max;

  assign at_max = (q_q == {W{1'b1}});

  always_comb begin
    q_d = q_q;
    if (inc) begin
      if (WRAP || !at_max) begin
        q_d = q_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/tdm_demux.sv
// Receive side of a two-slot TDM link: pairs the sof-flagged A word with the
// following B word, strobes the pair out, and counts frames and framing errors.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [N-1:0]     out_a,
  output logic [N-1:0]     out_b,
  output logic             out_valid,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a word is consumed on every posedge where din_valid=1; there is
  // no backpressure. out_valid/sync_err are single-cycle registered strobes.

  logic         state_q;
  logic         state_d;
  logic [N-1:0] a_hold_q;
  logic [N-1:0] a_hold_d;
  logic [N-1:0] out_a_q;
  logic [N-1:0] out_a_d;
  logic [N-1:0] out_b_q;
  logic [N-1:0] out_b_d;
  logic         out_valid_q;
  logic         sync_err_q;

  logic         load_a;
  logic         frame_done;
  logic         frame_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      case (state_q)
        ST_HUNT:  state_d = sof ? ST_GOT_A : ST_HUNT;
        ST_GOT_A: state_d = sof ? ST_GOT_A : ST_HUNT;
        default:  state_d = ST_HUNT;
      endcase
    end
  end

  // Output/action decode. A second sof while holding A is a lost B word:
  // flag it and restart the frame from the new A.
  always_comb begin
    load_a     = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sof) begin
            load_a = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        ST_GOT_A: begin
          if (sof) begin
            frame_err = 1'b1;
            load_a    = 1'b1;
          end else begin
            frame_done = 1'b1;
          end
        end
        default: begin
          frame_err = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    a_hold_d = load_a ? din : a_hold_q;
    out_a_d  = frame_done ? a_hold_q : out_a_q;
    out_b_d  = frame_done ? din : out_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      a_hold_q    <= a_hold_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= frame_done;
      sync_err_q  <= frame_err;
    end
  end

  sat_counter #(
    .W    (CNT_W),
    .WRAP (1'b1)
  ) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_done),
    .q   (frame_cnt)
  );

  sat_counter #(
    .W    (CNT_W),
    .WRAP (1'b0)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_err),
    .q   (err_cnt)
  );

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule : tdm_demux
